// File: rtl/vga_sync_gen_if.sv
// Signal bundle between a horizontal timing source and the vertical sync generator.
// The master drives the line position and line-end strobe; the slave returns sync and pixel info.
interface vga_sync_gen_if;
    logic        enable_V_Counter;
    logic [15:0] H_Count_Value;
    logic [15:0] V_Count_Value;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic [7:0]  frame_count;

    modport master (
        output enable_V_Counter, H_Count_Value,
        input  V_Count_Value, hsync, vsync, video_on,
               pixel_x, pixel_y, frame_start, frame_count
    );

    modport slave (
        input  enable_V_Counter, H_Count_Value,
        output V_Count_Value, hsync, vsync, video_on,
               pixel_x, pixel_y, frame_start, frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Vertical line counter plus registered hsync/vsync/video_on/pixel coordinate generation.
// Counts frames and pulses frame_start on the cycle V first reads 0 after a wrap.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic           clk_25MHz,
    input  logic           rst_n,
    vga_sync_gen_if.slave  bus
);

    localparam logic [15:0] H_VIS_L      = 16'(H_VISIBLE);
    localparam logic [15:0] H_TOTAL_L    = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] HS_START_L   = 16'(H_VISIBLE + H_FP);
    localparam logic [15:0] HS_END_L     = 16'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [15:0] V_VIS_L      = 16'(V_VISIBLE);
    localparam logic [15:0] V_LAST_L     = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] VS_START_L   = 16'(V_VISIBLE + V_FP);
    localparam logic [15:0] VS_END_L     = 16'(V_VISIBLE + V_FP + V_SYNC);

    logic [15:0] v_cnt_q, v_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        frame_start_q, frame_start_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;

    logic        v_wrap;
    logic        h_in_line;
    logic        h_in_sync;
    logic        v_in_sync;

    // Out-of-range V values (>= last line) also wrap, so a corrupted counter recovers in one strobe.
    assign v_wrap    = bus.enable_V_Counter && (v_cnt_q >= V_LAST_L);
    assign h_in_line = bus.H_Count_Value < H_TOTAL_L;
    assign h_in_sync = h_in_line && (bus.H_Count_Value >= HS_START_L)
                       && (bus.H_Count_Value < HS_END_L);
    assign v_in_sync = (v_cnt_q >= VS_START_L) && (v_cnt_q < VS_END_L);

    always_comb begin
        v_cnt_d       = v_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        if (v_wrap) begin
            v_cnt_d       = '0;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            frame_start_d = 1'b1;
        end else if (bus.enable_V_Counter) begin
            v_cnt_d = v_cnt_q + 16'd1;
        end
    end

    // Display timing uses the V value present at the edge, not the one being loaded.
    always_comb begin
        hsync_d    = ~h_in_sync;
        vsync_d    = ~v_in_sync;
        video_on_d = h_in_line && (bus.H_Count_Value < H_VIS_L) && (v_cnt_q < V_VIS_L);
        pixel_x_d  = '0;
        pixel_y_d  = '0;
        if (video_on_d) begin
            pixel_x_d = bus.H_Count_Value[9:0];
            pixel_y_d = v_cnt_q[9:0];
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            v_cnt_q       <= '0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else begin
            v_cnt_q       <= v_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
        end
    end

    assign bus.V_Count_Value = v_cnt_q;
    assign bus.frame_count   = frame_cnt_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.video_on      = video_on_q;
    assign bus.pixel_x       = pixel_x_q;
    assign bus.pixel_y       = pixel_y_q;

endmodule
